// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with field decode, immediate generation, load-use and writeback hazard detection.
// Latency 1 cycle; holds when ex_valid & !ex_ready. `define ID_EX_BYPASS_EN forwards wb_data instead of stalling on writeback.
module id_ex_stage #(
  parameter int n = 32,
  parameter int m = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [n-1:0] id_instr,
  input  logic [n-1:0] id_pc,
  output logic         id_ready,
  output logic [m-1:0] rf_rs1,
  output logic [m-1:0] rf_rs2,
  input  logic [n-1:0] rf_rdata1,
  input  logic [n-1:0] rf_rdata2,
  input  logic         wb_en,
  input  logic [m-1:0] wb_rd,
  input  logic [n-1:0] wb_data,
  input  logic         flush,
  input  logic         ex_ready,
  output logic         ex_valid,
  output logic [n-1:0] ex_op1,
  output logic [n-1:0] ex_op2,
  output logic [n-1:0] ex_imm,
  output logic [n-1:0] ex_pc,
  output logic [m-1:0] ex_rd,
  output logic [6:0]   ex_opcode,
  output logic [2:0]   ex_funct3,
  output logic         ex_funct7b5,
  output logic         ex_is_load
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic [6:0]   opcode;
  logic         use_rs1, use_rs2;
  logic         load_use, wb_hit1, wb_hit2, hazard, transfer;
  logic [n-1:0] op1_nxt, op2_nxt;
  logic [31:0]  imm32;

  assign opcode  = id_instr[6:0];
  assign rf_rs1  = id_instr[15 +: m];
  assign rf_rs2  = id_instr[20 +: m];
  assign use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign use_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);

  assign ex_is_load = (ex_opcode == OP_LOAD);

  assign load_use = ex_valid & ex_is_load & (ex_rd != '0) &
                    ((use_rs1 & (rf_rs1 == ex_rd)) | (use_rs2 & (rf_rs2 == ex_rd)));
  assign wb_hit1  = wb_en & (wb_rd != '0) & use_rs1 & (wb_rd == rf_rs1);
  assign wb_hit2  = wb_en & (wb_rd != '0) & use_rs2 & (wb_rd == rf_rs2);

`ifdef ID_EX_BYPASS_EN
  assign hazard  = load_use;
  assign op1_nxt = (rf_rs1 == '0) ? '0 : (wb_hit1 ? wb_data : rf_rdata1);
  assign op2_nxt = (rf_rs2 == '0) ? '0 : (wb_hit2 ? wb_data : rf_rdata2);
`else
  // Without forwarding the register file is re-read the cycle after the write lands.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign hazard  = load_use | wb_hit1 | wb_hit2;
  assign op1_nxt = (rf_rs1 == '0) ? '0 : rf_rdata1;
  assign op2_nxt = (rf_rs2 == '0) ? '0 : rf_rdata2;
`endif

  assign id_ready = (!ex_valid | ex_ready) & !hazard;
  assign transfer = id_valid & id_ready;

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYS, OP_FENCE:
        imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
      OP_S:
        imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      OP_B:
        imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {id_instr[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid    <= 1'b1;
      ex_op1      <= op1_nxt;
      ex_op2      <= op2_nxt;
      ex_imm      <= {{(n-31){imm32[31]}}, imm32[30:0]};
      ex_pc       <= id_pc;
      ex_rd       <= id_instr[7 +: m];
      ex_opcode   <= opcode;
      ex_funct3   <= id_instr[14:12];
      ex_funct7b5 <= id_instr[30];
    end else if (!ex_valid | ex_ready) begin
      // Nothing accepted: insert a bubble, data registers keep their last value.
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/hazard/reset sequences, randomized run against a model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic        id_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_is_load;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.n(32), .m(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_is_load(ex_is_load)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_instr = 32'h0000_0013; id_pc = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic flush_cycle();
    @(negedge clk); idle(); flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [31:0] op1, op2, imm, pc;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  function automatic bit uses1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        i12 = ins[31:20];
        return {{20{i12[11]}}, i12};
      end
      7'b0100011: begin
        i12 = {ins[31:25], ins[11:7]};
        return {{20{i12[11]}}, i12};
      end
      7'b1100011: begin
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return {{19{b13[12]}}, b13};
      end
      7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
      7'b1101111: begin
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return {{11{j21[20]}}, j21};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] rdata, input bit used);
    if (a == 0) return 32'h0;
`ifdef ID_EX_BYPASS_EN
    if (used && wb_en && wb_rd == a) return wb_data;
`endif
    return rdata;
  endfunction

  function automatic bit ref_hazard(input ex_t s);
    logic [6:0] op = id_instr[6:0];
    logic [4:0] a1 = id_instr[19:15];
    logic [4:0] a2 = id_instr[24:20];
    bit h = 0;
    if (s.v && s.opc == 7'b0000011 && s.rd != 0 &&
        ((uses1(op) && a1 == s.rd) || (uses2(op) && a2 == s.rd))) h = 1;
`ifndef ID_EX_BYPASS_EN
    if (wb_en && wb_rd != 0 && ((uses1(op) && a1 == wb_rd) || (uses2(op) && a2 == wb_rd))) h = 1;
`endif
    return h;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        wben;
    logic [4:0]  wbrd;
    logic [31:0] wbdat, e_op1, e_op2, e_imm;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vt[9];
  ex_t  ms;
  logic [6:0] oplist[9];
  logic [31:0] held_op1, held_imm;

  initial begin
    vt[0] = '{32'h0050_0293, 32'h1111, 32'h22, 1'b0, 5'd0, 32'h0, 32'h0,  32'h22, 32'h5,         5'd5};
    vt[1] = '{32'h0063_03B3, 32'hA,    32'hB,  1'b0, 5'd0, 32'h0, 32'hA,  32'hB,  32'h0,         5'd7};
    vt[2] = '{32'h4031_00B3, 32'h3,    32'h4,  1'b0, 5'd0, 32'h0, 32'h3,  32'h4,  32'h0,         5'd1};
    vt[3] = '{32'hFE51_2E23, 32'h5,    32'h6,  1'b0, 5'd0, 32'h0, 32'h5,  32'h6,  32'hFFFF_FFFC, 5'd28};
    vt[4] = '{32'hFE20_8CE3, 32'h7,    32'h8,  1'b0, 5'd0, 32'h0, 32'h7,  32'h8,  32'hFFFF_FFF8, 5'd25};
    vt[5] = '{32'h1234_51B7, 32'h9,    32'hC,  1'b0, 5'd0, 32'h0, 32'h9,  32'hC,  32'h1234_5000, 5'd3};
    vt[6] = '{32'h0010_00EF, 32'hD,    32'hE,  1'b0, 5'd0, 32'h0, 32'h0,  32'hE,  32'h800,       5'd1};
    vt[7] = '{32'h0000_A303, 32'hF,    32'h10, 1'b0, 5'd0, 32'h0, 32'hF,  32'h0,  32'h0,         5'd6};
    vt[8] = '{32'h0000_0433, 32'h55,   32'h55, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,   5'd8};
    oplist = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
               7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    // Reset state
    idle(); rst = 1;
    #3;
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_ex_op1", ex_op1, 0);
    chk("reset_ex_imm", ex_imm, 0);
    chk("reset_ex_pc", ex_pc, 0);
    @(negedge clk); @(negedge clk); rst = 0;

    // Table vectors, each from an empty stage
    for (int i = 0; i < 9; i++) begin
      flush_cycle();
      @(negedge clk);
      id_valid = 1; id_instr = vt[i].instr; id_pc = 32'h1000 + 32'(4 * i);
      rf_rdata1 = vt[i].rd1; rf_rdata2 = vt[i].rd2;
      wb_en = vt[i].wben; wb_rd = vt[i].wbrd; wb_data = vt[i].wbdat;
      #1;
      chk($sformatf("vec%0d_id_ready", i), id_ready, 1);
      chk($sformatf("vec%0d_rf_rs1", i), rf_rs1, vt[i].instr[19:15]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ex_valid", i), ex_valid, 1);
      chk($sformatf("vec%0d_ex_op1", i), ex_op1, vt[i].e_op1);
      chk($sformatf("vec%0d_ex_op2", i), ex_op2, vt[i].e_op2);
      chk($sformatf("vec%0d_ex_imm", i), ex_imm, vt[i].e_imm);
      chk($sformatf("vec%0d_ex_rd", i), ex_rd, vt[i].e_rd);
      chk($sformatf("vec%0d_ex_pc", i), ex_pc, 32'h1000 + 32'(4 * i));
    end

    // Load-use: LW x6,0(x1) then ADD x7,x6,x6
    flush_cycle();
    @(negedge clk); id_valid = 1; id_instr = 32'h0000_A303; ex_ready = 1;
    @(posedge clk); #1;
    chk("lu_is_load", ex_is_load, 1);
    @(negedge clk); id_instr = 32'h0063_03B3; #1;
    chk("lu_id_ready_stall", id_ready, 0);
    @(posedge clk); #1;
    chk("lu_bubble", ex_valid, 0);
    @(negedge clk); #1;
    chk("lu_id_ready_resume", id_ready, 1);
    @(posedge clk); #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 7);

    // Writeback match on x6: forward or one bubble
    flush_cycle();
    @(negedge clk);
    id_valid = 1; id_instr = 32'h0013_0493; rf_rdata1 = 0;
    wb_en = 1; wb_rd = 6; wb_data = 32'hDEAD_BEEF; #1;
`ifdef ID_EX_BYPASS_EN
    chk("byp_id_ready", id_ready, 1);
    @(posedge clk); #1;
    chk("byp_ex_valid", ex_valid, 1);
    chk("byp_ex_op1", ex_op1, 32'hDEAD_BEEF);
`else
    chk("wbh_id_ready", id_ready, 0);
    @(posedge clk); #1;
    chk("wbh_bubble", ex_valid, 0);
    @(negedge clk); wb_en = 0; rf_rdata1 = 32'hDEAD_BEEF; #1;
    chk("wbh_id_ready_resume", id_ready, 1);
    @(posedge clk); #1;
    chk("wbh_ex_valid", ex_valid, 1);
    chk("wbh_ex_op1", ex_op1, 32'hDEAD_BEEF);
`endif

    // Back-pressure hold for 3 cycles, then flush during stall
    flush_cycle();
    @(negedge clk); idle(); id_valid = 1; id_instr = 32'h0050_0293;
    @(posedge clk); #1;
    held_op1 = ex_op1; held_imm = 32'h5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ex_ready = 0; id_instr = 32'h0010_0313; rf_rdata1 = 32'h77; #1;
      chk("stall_id_ready", id_ready, 0);
      @(posedge clk); #1;
      chk("stall_ex_valid", ex_valid, 1);
      chk("stall_ex_imm", ex_imm, held_imm);
      chk("stall_ex_rd", ex_rd, 5);
      chk("stall_ex_op1", ex_op1, 0);
    end
    @(negedge clk); flush = 1;
    @(posedge clk); #1;
    chk("stall_flush", ex_valid, 0);

    // Async reset mid-stall, then ready right after release
    @(negedge clk); idle(); id_valid = 1; id_instr = 32'h0050_0293;
    @(posedge clk); #1;
    @(negedge clk); ex_ready = 0; id_valid = 0;
    @(posedge clk); #1;
    @(negedge clk); #2; rst = 1; #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_imm", ex_imm, 0);
    chk("arst_ex_rd", ex_rd, 0);
    @(negedge clk); rst = 0; id_valid = 1; id_instr = 32'h0050_0293; ex_ready = 0; #1;
    chk("arst_id_ready", id_ready, 1);
    @(posedge clk); #1;
    chk("arst_capture", ex_valid, 1);

    // Randomized run against the model
    flush_cycle();
    ms = '{default: '0};
    for (int c = 0; c < 3000; c++) begin
      bit h, rdy;
      logic [31:0] ins;
      @(negedge clk);
      ins = $urandom;
      ins[6:0]   = oplist[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      id_instr = ins; id_pc = $urandom;
      id_valid = ($urandom_range(0, 3) != 0);
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      wb_en = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      h = ref_hazard(ms);
      rdy = (!ms.v || ex_ready) && !h;
      #1;
      chk("rnd_id_ready", id_ready, rdy);
      chk("rnd_rf_rs2", rf_rs2, ins[24:20]);
      if (flush) ms.v = 0;
      else if (id_valid && rdy) begin
        ms.v = 1;
        ms.op1 = ref_src(ins[19:15], rf_rdata1, uses1(ins[6:0]));
        ms.op2 = ref_src(ins[24:20], rf_rdata2, uses2(ins[6:0]));
        ms.imm = ref_imm(ins); ms.pc = id_pc; ms.rd = ins[11:7];
        ms.opc = ins[6:0]; ms.f3 = ins[14:12]; ms.f7 = ins[30];
      end else if (!ms.v || ex_ready) ms.v = 0;
      @(posedge clk); #1;
      chk("rnd_ex_valid", ex_valid, ms.v);
      if (ms.v) begin
        chk("rnd_ex_op1", ex_op1, ms.op1);
        chk("rnd_ex_op2", ex_op2, ms.op2);
        chk("rnd_ex_imm", ex_imm, ms.imm);
        chk("rnd_ex_pc", ex_pc, ms.pc);
        chk("rnd_fields", {ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load},
            {ms.rd, ms.opc, ms.f3, ms.f7, ms.opc == 7'b0000011});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
